// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the multi-cycle instruction fetch stage.
//   IFU_XLEN      - default PC/address width
//   IFU_RESET_PC  - default PC loaded on reset
//   NOP_INST      - instruction presented alongside a misaligned-PC fault
//   fetch_state_e - fetch FSM states (request, wait for response, hold for decoder)
package ifu_fetch_pkg;

  localparam int unsigned IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch stage. Owns the architectural PC,
// keeps at most one request outstanding to instruction memory and presents
// each fetched word to the decoder until it is consumed.
// Ports:
//   clk_i, rst_n_i                 - clock, synchronous active-low reset
//   redirect_valid_i/redirect_pc_i - next-PC override from execute
//   imem_req_valid_o/ready_i/addr_o - request channel (addr = current PC)
//   imem_rsp_valid_i/data_i/err_i  - response channel, single-cycle pulse
//   inst_valid_o/ready_i           - decoder handshake
//   inst_o/inst_pc_o/inst_err_o    - registered instruction, its PC, fault flag
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_err_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_err_q, inst_err_d;

  logic misaligned;
  logic req_fire;

  assign misaligned = (pc_q[1:0] != 2'b00);

  // Request outputs depend only on state and pc (plus reset gating).
  assign imem_req_valid_o = rst_n_i && (state_q == ST_REQ) && !misaligned;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign inst_valid_o = (state_q == ST_HOLD);
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_err_o   = inst_err_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;

    unique case (state_q)
      ST_REQ: begin
        if (req_fire) begin
          state_d = ST_WAIT;
          // A redirect racing the handshake leaves an in-flight request
          // whose response must be dropped.
          kill_d  = redirect_valid_i;
        end else if (misaligned && !redirect_valid_i) begin
          state_d    = ST_HOLD;
          inst_d     = NOP_INST;
          inst_pc_d  = pc_q;
          inst_err_d = 1'b1;
        end
        if (redirect_valid_i) pc_d = redirect_pc_i;
      end

      ST_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (kill_q || redirect_valid_i) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d     = imem_rsp_data_i;
            inst_pc_d  = pc_q;
            inst_err_d = imem_rsp_err_i;
            state_d    = ST_HOLD;
          end
        end else if (redirect_valid_i) begin
          kill_d = 1'b1;
        end
        if (redirect_valid_i) pc_d = redirect_pc_i;
      end

      ST_HOLD: begin
        // Redirect wins over sequential advance even if the decoder consumes.
        if (redirect_valid_i) begin
          pc_d    = redirect_pc_i;
          state_d = ST_REQ;
        end else if (inst_ready_i) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

  // Only one request is ever outstanding, so a response outside WAIT is a
  // memory-side protocol violation; the FSM ignores it.
  a_rsp_only_in_wait: assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
      imem_rsp_valid_i |-> (state_q == ST_WAIT)
  );

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Multi-cycle instruction fetch stage that replaces the combinational fetch path for the non-ideal-memory core. Owns the architectural PC and issues one outstanding request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. Presents the fetched instruction and its PC to the decoder over a valid/ready handshake. Accepts redirects (jal/jalr/branch targets) from the execute stage.

## Interface
Parameters:
- `XLEN`, 32: PC/address width.
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.

Ports:
- `clk_i` in 1: clock. One clock domain; all state updates on posedge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `redirect_valid_i` in 1: next PC is overridden this cycle.
- `redirect_pc_i` in XLEN: redirect target.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: memory accepts request.
- `imem_req_addr_o` out XLEN: fetch address, equal to the current PC.
- `imem_rsp_valid_i` in 1: response valid, 1-cycle pulse, no backpressure.
- `imem_rsp_data_i` in 32: instruction word.
- `imem_rsp_err_i` in 1: access fault on this response.
- `inst_valid_o` out 1: instruction available to decoder.
- `inst_ready_i` in 1: decoder consumes instruction.
- `inst_o` out 32: instruction word.
- `inst_pc_o` out XLEN: PC of `inst_o`.
- `inst_err_o` out 1: fetch fault (memory error or misaligned PC).

## Operation
- States: REQ, WAIT, HOLD.
- Reset (`rst_n_i`=0 at posedge): state←REQ, pc←RESET_PC, kill←0, `inst_valid_o`=0, `inst_o`=0, `inst_pc_o`=0, `inst_err_o`=0. `imem_req_valid_o` is low while `rst_n_i`=0.
- REQ: `imem_req_valid_o`=1, addr=pc.
  - Handshake (valid&ready) → WAIT.
  - pc[1:0]≠0 → no request issued; go HOLD with `inst_err_o`=1, `inst_o`=32'h0000_0013, `inst_pc_o`=pc.
- WAIT: on `imem_rsp_valid_i`:
  - kill=0 → latch data/err/pc into output regs, go HOLD.
  - kill=1 → discard the response, clear kill, go REQ.
- HOLD: `inst_valid_o`=1; outputs are stable until handshake.
  - On `inst_ready_i` → pc←pc+4 (mod 2^XLEN, wraps silently), go REQ.
- Redirect (highest priority for the next PC):
  - REQ without handshake: pc←target, stay REQ. The address may change while valid is high only in this case.
  - REQ with handshake in the same cycle: pc←target, kill←1, go WAIT.
  - WAIT: pc←target, kill←1. A response arriving in the same cycle is discarded, kill is cleared, go REQ.
  - HOLD: pc←target, go REQ. `inst_valid_o` drops the next cycle. If `inst_ready_i` is also high, the instruction counts as consumed but no +4 is applied.
- Only one request is ever outstanding. A response in REQ or HOLD is a protocol violation; it is ignored and asserted in simulation.

## Timing
- First request: the cycle after `rst_n_i` rises.
- Request accepted at cycle N; response at N+k (k≥1); `inst_valid_o` registered high at N+k+1.
- Best-case throughput is 1 instruction per 3 cycles: REQ, WAIT, HOLD.
- `inst_*` outputs are registered, with no combinational path from `imem_rsp_*`.
- `imem_req_*` depend only on state and pc, with no combinational path from `imem_req_ready_i`.
- Reset mid-operation overrides everything. A response to the pre-reset request must not arrive after reset, and is ignored if it does.

## Structure
- Shared package: state enum (REQ/WAIT/HOLD), `NOP_INST`=32'h0000_0013, default `RESET_PC`, and `XLEN` reused from the existing defines.
- Single module. No sub-module; the pc/kill registers and FSM are small enough to stay flat.

## Test plan
- Reset, then memory with ready=1 and 1-cycle latency returning 0x00000013 → requests at 0x80000000, 0x80000004, 0x80000008. `inst_valid_o` every 3rd cycle, `inst_pc_o` matching.
- Decoder holds `inst_ready_i`=0 for 5 cycles → `inst_o`/`inst_pc_o` stable, no new request issued; release → next request at pc+4.
- Redirect to 0x80000100 while in WAIT, response arriving 3 cycles later → response dropped, next request at 0x80000100, `inst_valid_o` never high for the stale word.
- Redirect and `inst_ready_i` in the same HOLD cycle → next request at the target, not pc+4.
- Redirect to 0x80000102 → no memory request. `inst_valid_o`=1, `inst_err_o`=1, `inst_o`=0x00000013, `inst_pc_o`=0x80000102.
- `imem_rsp_err_i`=1 at pc 0x80000008 → `inst_err_o`=1 with `inst_pc_o`=0x80000008; pull `rst_n_i` low mid-WAIT → all outputs 0, pc=0x80000000.
